gpu_task_scheduler: RTL

GPU_TASK_SCHEDULER -- requirements
Module: gpu_task_scheduler

---
 rtl/gpu_pkg.sv | 14 +
 rtl/gpu_kernel_buf.sv | 17 +
 rtl/gpu_task_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared sizes, opcode constants and scheduler state encoding.
package gpu_pkg;
  localparam int NUM_CORES = 4;
  localparam int PROG_LEN = 16;
  localparam int INS_W = 16;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LD = 4'h3;
  localparam logic [3:0] OP_ST = 4'h4;
  localparam logic [3:0] OP_BR = 4'h5;
  localparam logic [3:0] OP_RET = 4'hF;
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_STREAM, S_WAIT_RDY, S_DONE} sched_state_e;
endpackage

// File: rtl/gpu_kernel_buf.sv
// gpu_kernel_buf: kernel word store, one write port and one asynchronous read port.
module gpu_kernel_buf #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/gpu_task_scheduler.sv
// gpu_task_scheduler: streams the kernel buffer to each masked core in turn, then waits for all to report ready.
module gpu_task_scheduler import gpu_pkg::*; #(
  parameter int NUM_CORES = gpu_pkg::NUM_CORES,
  parameter int PROG_LEN = gpu_pkg::PROG_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_we,
  input  logic [3:0]           host_addr,
  input  logic [INS_W-1:0]     host_wdata,
  input  logic                 launch,
  input  logic [NUM_CORES-1:0] core_mask,
  output logic                 busy,
  output logic                 done,
  output logic [INS_W-1:0]     instruction,
  output logic [NUM_CORES-1:0] val_ins,
  input  logic [NUM_CORES-1:0] rtr,
  input  logic [NUM_CORES-1:0] ready
);
  localparam int IW = $clog2(PROG_LEN);
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  sched_state_e state_q, state_d;
  logic [NUM_CORES-1:0] pending_q, pending_d, launch_mask_q, launch_mask_d, val_ins_q, val_ins_d;
  logic [CW-1:0] cur_q, cur_d, sel;
  logic [IW-1:0] idx_q, idx_d, rd_addr;
  logic [INS_W-1:0] ins_q, ins_d, rd_data;
  logic busy_q, busy_d, done_q, done_d, xfer;
  // Look one word ahead while streaming so the next word is on the bus right after a transfer.
  assign rd_addr = state_q == S_STREAM ? idx_q + IW'(1) : idx_q;
  assign xfer = val_ins_q[cur_q] & rtr[cur_q];
  gpu_kernel_buf #(.DEPTH(PROG_LEN), .AW(IW), .W(INS_W)) u_buf (
    .clk(clk), .we(host_we & ~busy_q), .waddr(host_addr[IW-1:0]), .wdata(host_wdata),
    .raddr(rd_addr), .rdata(rd_data)
  );
  always_comb begin
    sel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) if (pending_q[i]) sel = CW'(i);
  end
  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    launch_mask_d = launch_mask_q;
    cur_d = cur_q;
    idx_d = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    val_ins_d = val_ins_q;
    ins_d = ins_q;
    case (state_q)
      S_IDLE: if (launch) begin
        pending_d = core_mask;
        launch_mask_d = core_mask;
        idx_d = '0;
        busy_d = 1'b1;
        state_d = S_SEL;
      end
      S_SEL: if (pending_q == '0) state_d = S_WAIT_RDY;
      else begin
        cur_d = sel;
        pending_d = pending_q & ~(NUM_CORES'(1) << sel);
        val_ins_d = NUM_CORES'(1) << sel;
        ins_d = rd_data;
        state_d = S_STREAM;
      end
      S_STREAM: if (xfer) begin
        idx_d = idx_q == IW'(PROG_LEN - 1) ? '0 : idx_q + IW'(1);
        val_ins_d = idx_q == IW'(PROG_LEN - 1) ? '0 : val_ins_q;
        ins_d = idx_q == IW'(PROG_LEN - 1) ? ins_q : rd_data;
        state_d = idx_q == IW'(PROG_LEN - 1) ? S_SEL : S_STREAM;
      end
      S_WAIT_RDY: if ((ready & launch_mask_q) == launch_mask_q) begin
        done_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pending_q <= '0;
      launch_mask_q <= '0;
      cur_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      val_ins_q <= '0;
      ins_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      launch_mask_q <= launch_mask_d;
      cur_q <= cur_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      val_ins_q <= val_ins_d;
      ins_q <= ins_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign val_ins = val_ins_q;
  assign instruction = ins_q;
endmodule
